// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding and timeout default for the data-memory controller
package dmem_pkg;
    localparam int TIMEOUT_DEF = 15;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: wait-state counter; expired marks the cycle the count reaches LIMIT
module dmem_timer #(
    parameter int LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign o_expired = i_enable && cnt == W'(LIMIT - 1);
    always_ff @(posedge i_clk) begin
        if (i_clear) cnt <= '0;
        else if (i_enable) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: stalls the core while a single data access runs against a ready/valid memory port
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ADDR_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_memReq,
    input  logic              i_memWrite,
    input  logic [ADDR_W-1:0] i_addr,
    inout  wire  [31:0]       io_dmemData,
    output logic              o_stall,
    output logic              o_memValid,
    output logic              o_memWe,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memWdata,
    input  logic              i_memReady,
    input  logic [31:0]       i_memRdata,
    output logic              o_busErr
);
    state_t      state;
    logic        rd_q;
    logic [31:0] data_q;
    logic        expired;
    // while reset is held the stall decision treats the FSM as already idle
    assign o_stall = (i_memReq && (state == IDLE || !i_reset)) || (state == REQ && i_reset);
    assign io_dmemData = (state == RESP && rd_q) ? data_q : 32'bz;
    dmem_timer #(.LIMIT(TIMEOUT)) u_timer (
        .i_clk    (i_clk),
        .i_clear  (!i_reset || state != REQ),
        .i_enable (state == REQ && !i_memReady),
        .o_expired(expired)
    );
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= IDLE;
            o_memValid <= 1'b0;
            o_memWe    <= 1'b0;
            o_memAddr  <= '0;
            o_memWdata <= '0;
            rd_q       <= 1'b0;
            data_q     <= '0;
            o_busErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_memReq) begin
                    rd_q <= !i_memWrite;
                    if (i_addr[1:0] == 2'b00) begin
                        state      <= REQ;
                        o_memValid <= 1'b1;
                        o_memWe    <= i_memWrite;
                        o_memAddr  <= i_addr;
                        o_memWdata <= io_dmemData;
                    end else begin
                        state    <= RESP;
                        o_busErr <= 1'b1;
                        data_q   <= '0;
                    end
                end
                REQ: if (i_memReady) begin
                    state      <= RESP;
                    o_memValid <= 1'b0;
                    if (!o_memWe) data_q <= i_memRdata;
                end else if (expired) begin
                    state      <= RESP;
                    o_memValid <= 1'b0;
                    o_busErr   <= 1'b1;
                    data_q     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized accesses checked against a per-transaction timing model
module tb_dmem_ctrl;
    localparam int TO = 15;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] addr;
    wire  [31:0] bus;
    logic        stall;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic        tb_oe;
    logic [31:0] tb_bus;
    logic        err_m;
    int          n_chk = 0;
    int          n_fail = 0;
    assign bus = tb_oe ? tb_bus : 32'bz;
    always #5 clk = ~clk;
    dmem_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .i_clk      (clk),
        .i_reset    (reset_n),
        .i_memReq   (mem_req),
        .i_memWrite (mem_write),
        .i_addr     (addr),
        .io_dmemData(bus),
        .o_stall    (stall),
        .o_memValid (mem_valid),
        .o_memWe    (mem_we),
        .o_memAddr  (mem_addr),
        .o_memWdata (mem_wdata),
        .i_memReady (mem_ready),
        .i_memRdata (mem_rdata),
        .o_busErr   (bus_err)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_req = 1'b0;
            mem_ready = 1'($urandom % 2);
            tb_oe = 1'b1;
            tb_bus = $urandom;
            #1;
            check("idle_stall", 32'(stall), 0);
            check("idle_valid", 32'(mem_valid), 0);
            check("idle_err", 32'(bus_err), 32'(err_m));
            check("idle_bus", bus, tb_bus);
        end
    endtask
    // w = idle memory cycles before ready; w >= TO means ready never comes in time
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int w, input logic [31:0] rd);
        logic mis, to;
        int nv;
        logic [31:0] exp_rd;
        mis = a[1:0] != 2'b00;
        to = !mis && w >= TO;
        nv = mis ? 0 : (w < TO ? w + 1 : TO);
        exp_rd = (mis || to) ? 32'h0 : rd;
        @(negedge clk);
        mem_req = 1'b1;
        mem_write = wr;
        addr = a;
        tb_oe = 1'b1;
        tb_bus = wr ? d : $urandom;
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
        #1;
        check("start_stall", 32'(stall), 1);
        check("start_valid", 32'(mem_valid), 0);
        check("start_err", 32'(bus_err), 32'(err_m));
        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            mem_ready = (i == w);
            mem_rdata = (i == w) ? rd : $urandom;
            addr = $urandom;
            tb_bus = $urandom;
            #1;
            check("req_valid", 32'(mem_valid), 1);
            check("req_stall", 32'(stall), 1);
            check("req_we", 32'(mem_we), 32'(wr));
            check("req_addr", mem_addr, a);
            if (wr) check("req_wdata", mem_wdata, d);
            check("req_err", 32'(bus_err), 32'(err_m));
            check("req_bus", bus, tb_bus);
        end
        if (mis || to) err_m = 1'b1;
        @(negedge clk);
        mem_req = 1'($urandom % 2);
        mem_ready = 1'($urandom % 2);
        mem_write = 1'($urandom % 2);
        addr = $urandom;
        tb_oe = wr;
        tb_bus = $urandom;
        #1;
        check("resp_valid", 32'(mem_valid), 0);
        check("resp_stall", 32'(stall), 0);
        check("resp_err", 32'(bus_err), 32'(err_m));
        check("resp_bus", bus, wr ? tb_bus : exp_rd);
    endtask
    task automatic abort(input logic [31:0] a);
        @(negedge clk);
        mem_req = 1'b1;
        mem_write = 1'b0;
        addr = a;
        tb_oe = 1'b1;
        tb_bus = $urandom;
        mem_ready = 1'b0;
        #1;
        check("ab_stall", 32'(stall), 1);
        @(negedge clk);
        #1;
        check("ab_valid1", 32'(mem_valid), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ab_rst_stall", 32'(stall), 1);
        err_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset_n = 1'b1;
            mem_req = 1'b0;
            mem_ready = 1'($urandom % 2);
            tb_bus = $urandom;
            #1;
            check("ab_valid", 32'(mem_valid), 0);
            check("ab_stall_after", 32'(stall), 0);
            check("ab_err", 32'(bus_err), 0);
            check("ab_addr", mem_addr, 0);
            check("ab_bus", bus, tb_bus);
        end
    endtask
    initial begin
        reset_n = 1'b0;
        mem_req = 1'b0;
        mem_write = 1'b0;
        addr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tb_oe = 1'b1;
        tb_bus = 32'h5a5a_a5a5;
        err_m = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(mem_valid), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_err", 32'(bus_err), 0);
        check("rst_bus", bus, tb_bus);
        check("rst_stall_idle", 32'(stall), 0);
        mem_req = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall), 1);
        @(negedge clk);
        reset_n = 1'b1;
        mem_req = 1'b0;
        idle(1);
        access(1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        access(1'b1, 32'h204, 32'h12345678, 3, 32'h0);
        access(1'b0, 32'h40, 32'h0, TO - 1, 32'hCAFEF00D);
        idle(2);
        access(1'b0, 32'h103, 32'h0, 0, 32'h0);
        idle(1);
        abort(32'h300);
        access(1'b0, 32'h80, 32'h0, TO + 2, 32'h11111111);
        access(1'b0, 32'h0, 32'h0, 0, 32'hA0A0A0A0);
        access(1'b0, 32'h4, 32'h0, 0, 32'hB1B1B1B1);
        for (int n = 0; n < 400; n++) begin
            int r, p, w;
            logic [31:0] a;
            r = int'($urandom % 100);
            p = int'($urandom % 10);
            w = p < 7 ? int'($urandom % 4) : p == 7 ? TO - 1 : p == 8 ? TO : TO + 1;
            a = $urandom;
            if (($urandom % 100) < 85) a[1:0] = 2'b00;
            if (r < 5) begin
                a[1:0] = 2'b00;
                abort(a);
            end else if (r < 15) idle(1 + int'($urandom % 3));
            else access(1'($urandom % 2), a, $urandom, w, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, sets the maximum cycles o_memValid is held without i_memReady before abort.
REQ-002 Parameter ADDR_W, default 32, sets the address width.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-low reset.
REQ-005 i_memReq  input  1  core data-memory access request (core o_memReq).
REQ-006 i_memWrite  input  1  1 = store, 0 = load; valid with i_memReq.
REQ-007 i_addr  input  ADDR_W  byte address from the core ALU output.
REQ-008 io_dmemData  inout  32  core data bus; core drives store data, dmem_ctrl drives load data.
REQ-009 o_stall  output  1  core hold; the PC and register file do not update while high.
REQ-010 o_memValid  output  1  memory-side request valid.
REQ-011 o_memWe  output  1  memory-side write enable; valid with o_memValid.
REQ-012 o_memAddr  output  ADDR_W  word-aligned memory address; addr[1:0] = 0.
REQ-013 o_memWdata  output  32  memory-side store data.
REQ-014 i_memReady  input  1  memory accepts (write) or returns data (read) this cycle.
REQ-015 i_memRdata  input  32  read data; valid when i_memReady is high and o_memWe is 0.
REQ-016 o_busErr  output  1  sticky error flag: misaligned address or timeout.

Function
REQ-017 FSM states: IDLE, REQ, RESP.
REQ-018 IDLE: when i_memReq=1 and i_addr[1:0]=0, capture i_addr, i_memWrite and io_dmemData into registers and enter REQ on the next edge.
REQ-019 IDLE: when i_memReq=1 and i_addr[1:0]!=0, issue no memory access, set o_busErr, and enter RESP.
REQ-020 o_stall = (state==IDLE && i_memReq) || state==REQ, computed combinationally; it is low in RESP.
REQ-021 REQ: o_memValid=1, with o_memAddr, o_memWe and o_memWdata taken from the captured registers and held stable until i_memReady.
REQ-022 REQ with i_memReady=1: latch i_memRdata when the access is a read, then enter RESP; o_memValid falls on the same edge.
REQ-023 REQ: a wait counter increments each cycle without i_memReady; when it reaches TIMEOUT, set o_busErr, latch read data 0, and enter RESP.
REQ-024 RESP lasts exactly 1 cycle and drives io_dmemData with the latched read data when the access was a read; io_dmemData is high-Z in every other state and for writes.
REQ-025 RESP always returns to IDLE; a request present in the following cycle is a new access, which allows back-to-back accesses every 3 cycles minimum.
REQ-026 Minimum load/store latency: 2 stall cycles plus 1 RESP cycle with zero memory wait states.
REQ-027 i_memReady while not in REQ is ignored.
REQ-028 i_memReady in the same cycle the wait counter reaches TIMEOUT: ready wins and no error is raised.
REQ-029 o_busErr clears only on reset.

Reset
REQ-030 On i_reset=0 at a clock edge: state=IDLE, o_memValid=0, o_memWe=0, o_memAddr=0, o_memWdata=0, wait counter=0, latched data=0, o_busErr=0, io_dmemData high-Z.
REQ-031 Reset in REQ or RESP aborts the access and drops o_memValid on the next edge; no RESP cycle follows.
REQ-032 o_stall follows the combinational rule in REQ-020 during reset, using state IDLE.

Structure
REQ-033 The state encoding (IDLE/REQ/RESP) and the TIMEOUT default belong in shared package dmem_pkg.
REQ-034 The wait counter is one sub-module, dmem_timer, with clear/enable inputs and an expired output; width is $clog2(TIMEOUT+1).

Verification
REQ-035 Load, addr 0x100, i_memReady 1 cycle after o_memValid, i_memRdata 0xDEADBEEF -> o_stall high 2 cycles; in RESP io_dmemData = 0xDEADBEEF; o_busErr = 0.
REQ-036 Store, addr 0x204, data 0x12345678, ready after 3 wait cycles -> o_memValid held 4 cycles with o_memWe = 1, o_memAddr = 0x204, o_memWdata = 0x12345678; io_dmemData stays high-Z.
REQ-037 Load, addr 0x103 -> o_memValid never asserts; o_busErr = 1 from the next cycle; o_stall high 1 cycle.
REQ-038 Load with i_memReady never asserted -> after 15 REQ cycles, RESP drives 0x00000000 and o_busErr = 1.
REQ-039 i_reset low during the 2nd REQ cycle -> next cycle o_memValid = 0, state = IDLE, o_busErr = 0, no RESP cycle.
REQ-040 Two back-to-back loads at 0x0 and 0x4, zero wait states -> two separate o_memValid pulses, data returned in order, 3-cycle spacing.
